data_mem_slave: RTL and testbench
=================================

# data_mem_slave

Responder end of the MEM-stage data-memory interface: accepts the chip-enable / write-enable / byte-select / address / data request driven by the memory stage and serves it from an on-chip word array after a programmable number of wait states. While an access is outstanding it raises a stall request to the pipeline controller, so the MEM stage holds its request stable until the data phase completes. Byte lanes are big-endian: `sel_i[3]` is byte address 0 (`data[31:24]`), and `sel_i[0]` is byte address 3 (`data[7:0]`).

## Interface
- `ADDR_WIDTH`, default 10. Word-address width; the array holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 1. Extra wait states per access; legal range 0..15.
- `clk`  in  1  Clock. All state changes on the rising edge.
- `rst`  in  1  Reset. Synchronous and active-high (`RstEnable` = 1).
- `ce_i`  in  1  Request valid (chip enable) from the MEM stage.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  32  Byte address. Bits [1:0] are ignored; lanes are selected by `sel_i`.
- `sel_i`  in  4  Byte-lane enables, big-endian.
- `data_i`  in  32  Write data, already lane-replicated by the MEM stage.
- `data_o`  out  32  Read data, full word. The MEM stage extracts and extends the bytes it needs.
- `stallreq_o`  out  1  Pipeline stall request.
- `err_o`  out  1  Out-of-range access. Present only with `DMEM_BOUNDS_CHECK_EN`.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - `ce_i`=1 accepts the request.
  - On accept, latch `addr_i[ADDR_WIDTH+1:2]`, `we_i`, `sel_i` and `data_i`, load the counter with `WAIT_CYCLES`, and go to WAIT.
- WAIT:
  - If `ce_i`=0 (flush), abort: go to IDLE with no write.
  - Otherwise, if the counter is nonzero, decrement it.
  - If the counter is zero, perform the access at this edge and go to DONE.
- Write access: for each lane i with `sel_i[i]`=1, the array byte for that lane takes the latched data byte. Other lanes are unchanged. `sel_i`=0000 writes nothing.
- Read access: `data_o` is registered with the addressed word.
- Write access and `data_o`: a write leaves `data_o` unchanged.
- DONE: always returns to IDLE on the next edge. A new request cannot be accepted in DONE; it is accepted at the following IDLE.
- `stallreq_o` is combinational:
  - 1 when `ce_i`=1 in state IDLE.
  - 1 when `ce_i`=1 in state WAIT.
  - 0 in DONE.
  - 0 whenever `ce_i`=0.
- Address aliasing: bits above `ADDR_WIDTH+1` are ignored, so the array aliases (wraps) across the address space.
- Changes to request inputs after accept are ignored; only a drop of `ce_i` has effect.

## Timing
- Reset values:
  - State: IDLE.
  - Counter: 0.
  - `data_o`: 0.
  - `err_o`: 0.
  - `stallreq_o`: 0, since it is forced low during reset.
  - Array contents are not reset.
- Request accepted in cycle N:
  - `stallreq_o`=1 in cycles N..N+WAIT_CYCLES.
  - DONE is in cycle N+WAIT_CYCLES+1, with `stallreq_o`=0 and `data_o` valid.
- Stall length: each access stalls the pipeline for WAIT_CYCLES+1 cycles.
- Back-to-back accesses: the minimum spacing is WAIT_CYCLES+2 cycles.
- `WAIT_CYCLES`=0: the access happens at the edge after acceptance, giving 1 stall cycle.
- Read after write to the same word: returns the merged new value, because the write committed at an earlier edge.
- Reset asserted in WAIT: the pending write is dropped and the state returns to IDLE.
- `ce_i` falling in the same cycle the counter reaches 0: abort wins, and no write occurs.

## Configuration
- `DMEM_BOUNDS_CHECK_EN` defined:
  - Any set bit in `addr_i[31:ADDR_WIDTH+2]` (latched at accept) marks the access out of range.
  - An out-of-range access still completes with normal timing.
  - In DONE it drives `err_o`=1 for exactly one cycle and `data_o`=0.
  - Its write is suppressed.
- `DMEM_BOUNDS_CHECK_EN` undefined:
  - The `err_o` port is absent.
  - Upper address bits are ignored (aliasing).

## Structure
- Shared package `dmem_pkg`:
  - State encoding (IDLE=2'b00, WAIT=2'b01, DONE=2'b10).
  - Counter width constant (4).
  - Lane-to-byte mapping constants (lane 3 = bits 31:24).
- Sub-module `dmem_array`: the word array with a 4-bit per-byte write enable, one write port, one registered read port.
- The top level holds the FSM, counter, request latch and the bounds check.

## Test plan
- `WAIT_CYCLES`=2: write `32'hDEADBEEF` to 0x40 with sel 1111, then read 0x40.
  - The write stalls 3 cycles.
  - The read stalls 3 cycles, and DONE shows `data_o`=`32'hDEADBEEF`.
- Byte store `32'h5A5A5A5A` to 0x41 with sel 0100 over `32'h11223344`, then read 0x40 → `32'h115A3344`.
- Halfword store `32'hABCDABCD` to 0x42 with sel 0011 over `32'h11223344`, then read 0x40 → `32'h1122ABCD`. Sel 0000 leaves the word unchanged.
- Flush: accept a write to 0x80, drop `ce_i` in WAIT.
  - The state returns to IDLE.
  - `stallreq_o` goes to 0.
  - A read of 0x80 returns the old value.
- Reset in WAIT during a write:
  - State IDLE, `data_o`=0.
  - A subsequent read shows the word unmodified.
- With `DMEM_BOUNDS_CHECK_EN` and `ADDR_WIDTH`=10:
  - A write to 0x1000 gives `err_o`=1 for one cycle, and 0x0000 is unchanged.
  - Without the macro, the same write lands at 0x0000.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: FSM encoding, counter width
// and byte-lane mapping (big-endian: lane 3 is byte address 0, bits 31:24).
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } dmem_state_e;

  localparam int unsigned CntWidth  = 4;
  localparam int unsigned LaneWidth = 8;
  localparam int unsigned NumLanes  = 4;

  // Lane i occupies data[8*i+7:8*i], so lane 3 is data[31:24].
  function automatic int unsigned lane_lsb(input int unsigned lane);
    return lane * LaneWidth;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with per-byte write enables, one write port and one registered read port.
// Only the read register is reset; array contents are not.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned AddrWidth = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumLanes-1:0]  be_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**AddrWidth];
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NumLanes; i++) begin
      if (be_i[i]) begin
        mem_q[addr_i][lane_lsb(i) +: LaneWidth] <= wdata_i[lane_lsb(i) +: LaneWidth];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_slave.sv
// MEM-stage data-memory responder: latches a request, waits WAIT_CYCLES, then serves it
// from dmem_array while holding stallreq_o. Define DMEM_BOUNDS_CHECK_EN to add err_o.
module data_mem_slave
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stallreq_o
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic        err_o
`endif
);

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  localparam logic [CntWidth-1:0] WaitCnt = CntWidth'(WAIT_CYCLES);

  dmem_state_e           state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  oor_q, oor_d;

  logic                  oor_in;
  logic                  acc_fire, acc_we, acc_oor;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [3:0]            acc_sel;
  logic [31:0]           acc_data;
  logic [NumLanes-1:0]   mem_be;
  logic                  mem_re;
  logic [31:0]           mem_rdata;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];
  assign oor_in = BoundsEn && ((addr_i >> (ADDR_WIDTH + 2)) != 32'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    oor_d    = oor_q;
    acc_fire = 1'b0;
    acc_addr = addr_q;
    acc_we   = we_q;
    acc_sel  = sel_q;
    acc_data = wdata_q;
    acc_oor  = oor_q;
    unique case (state_q)
      StIdle: begin
        if (ce_i) begin
          addr_d  = addr_i[ADDR_WIDTH+1:2];
          we_d    = we_i;
          sel_d   = sel_i;
          wdata_d = data_i;
          oor_d   = oor_in;
          cnt_d   = WaitCnt;
          if (WAIT_CYCLES == 0) begin
            // No wait states: serve straight from the request inputs at this edge.
            acc_fire = 1'b1;
            acc_addr = addr_i[ADDR_WIDTH+1:2];
            acc_we   = we_i;
            acc_sel  = sel_i;
            acc_data = data_i;
            acc_oor  = oor_in;
            state_d  = StDone;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!ce_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q > 1) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d    = '0;
          acc_fire = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_be = (acc_fire && acc_we && !acc_oor) ? acc_sel : '0;
  assign mem_re = acc_fire && !acc_we && !acc_oor;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
    end
  end

  dmem_array #(
    .AddrWidth(ADDR_WIDTH)
  ) u_array (
    .clk_i  (clk),
    .rst_i  (rst),
    .be_i   (mem_be),
    .re_i   (mem_re),
    .addr_i (acc_addr),
    .wdata_i(acc_data),
    .rdata_o(mem_rdata)
  );

  assign stallreq_o = !rst && ce_i && (state_q == StIdle || state_q == StWait);
  // An out-of-range access shows zero data for its DONE cycle.
  assign data_o = (state_q == StDone && oor_q) ? 32'd0 : mem_rdata;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign err_o = (state_q == StDone) && oor_q;
`endif

endmodule

// File: tb/tb_data_mem_slave.sv
// Directed bench for data_mem_slave with WAIT_CYCLES=2, ADDR_WIDTH=10.
module tb_data_mem_slave;
  import dmem_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned WC = 2;

  logic        clk = 1'b0;
  logic        rst, ce_i, we_i;
  logic [31:0] addr_i, data_i, data_o;
  logic [3:0]  sel_i;
  logic        stallreq_o;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic        err_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic err_seen;

  always #5 clk = ~clk;

  data_mem_slave #(
    .ADDR_WIDTH (AW),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce_i      (ce_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .sel_i     (sel_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .stallreq_o(stallreq_o)
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    .err_o     (err_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full request: hold ce_i until the stall drops (DONE), capture data_o there.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] data, output logic [31:0] rd, output int stalls);
    @(negedge clk);
    ce_i   = 1'b1;
    we_i   = we;
    addr_i = addr;
    sel_i  = sel;
    data_i = data;
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!stallreq_o) break;
      stalls++;
      @(negedge clk);
    end
    rd = data_o;
    err_seen = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
    err_seen = err_o;
`endif
    ce_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          st;

    rst = 1'b1; ce_i = 1'b1; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stall", 32'(stallreq_o), 32'd0);
    check_eq("rst_data", data_o, 32'd0);
    check_eq("rst_state", 32'(dut.state_q), 32'(StIdle));
    check_eq("rst_cnt", 32'(dut.cnt_q), 32'd0);
    rst = 1'b0; ce_i = 1'b0;

    do_access(1'b1, 32'h40, 4'b1111, 32'hDEADBEEF, rd, st);
    check_eq("wr_stalls", 32'(st), 32'd3);
    do_access(1'b0, 32'h40, 4'b1111, 32'h0, rd, st);
    check_eq("rd_stalls", 32'(st), 32'd3);
    check_eq("rd_word", rd, 32'hDEADBEEF);

    do_access(1'b1, 32'h40, 4'b1111, 32'h11223344, rd, st);
    do_access(1'b1, 32'h41, 4'b0100, 32'h5A5A5A5A, rd, st);
    do_access(1'b0, 32'h40, 4'b1111, 32'h0, rd, st);
    check_eq("byte_store", rd, 32'h115A3344);
    do_access(1'b1, 32'h40, 4'b1111, 32'h11223344, rd, st);
    check_eq("wr_keeps_data_o", rd, 32'h115A3344);
    do_access(1'b1, 32'h42, 4'b0011, 32'hABCDABCD, rd, st);
    do_access(1'b0, 32'h40, 4'b1111, 32'h0, rd, st);
    check_eq("half_store", rd, 32'h1122ABCD);
    do_access(1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, rd, st);
    do_access(1'b0, 32'h40, 4'b1111, 32'h0, rd, st);
    check_eq("sel_none", rd, 32'h1122ABCD);

    // Flush in the last wait cycle: abort must win over the access.
    do_access(1'b1, 32'h80, 4'b1111, 32'hCAFEF00D, rd, st);
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h80; sel_i = 4'b1111; data_i = 32'h12345678;
    @(negedge clk);
    #1;
    check_eq("flush_wait_stall", 32'(stallreq_o), 32'd1);
    @(negedge clk);
    ce_i = 1'b0;
    #1;
    check_eq("flush_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    #1;
    check_eq("flush_state", 32'(dut.state_q), 32'(StIdle));
    do_access(1'b0, 32'h80, 4'b1111, 32'h0, rd, st);
    check_eq("flush_no_write", rd, 32'hCAFEF00D);

    // Reset while a write is waiting.
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h80; sel_i = 4'b1111; data_i = 32'h55AA55AA;
    @(negedge clk);
    rst = 1'b1; ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rstw_state", 32'(dut.state_q), 32'(StIdle));
    check_eq("rstw_data", data_o, 32'd0);
    check_eq("rstw_stall", 32'(stallreq_o), 32'd0);
    do_access(1'b0, 32'h80, 4'b1111, 32'h0, rd, st);
    check_eq("rstw_no_write", rd, 32'hCAFEF00D);

    // Address above the array: error with the bounds check, aliasing without.
    do_access(1'b1, 32'h0, 4'b1111, 32'h01020304, rd, st);
    do_access(1'b1, 32'h1000, 4'b1111, 32'h77777777, rd, st);
    check_eq("oor_stalls", 32'(st), 32'd3);
`ifdef DMEM_BOUNDS_CHECK_EN
    check_eq("oor_err", 32'(err_seen), 32'd1);
    check_eq("oor_data", rd, 32'd0);
    @(negedge clk);
    #1;
    check_eq("oor_err_one_cycle", 32'(err_o), 32'd0);
    do_access(1'b0, 32'h0, 4'b1111, 32'h0, rd, st);
    check_eq("oor_suppressed", rd, 32'h01020304);
`else
    do_access(1'b0, 32'h0, 4'b1111, 32'h0, rd, st);
    check_eq("alias_write", rd, 32'h77777777);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
